// File: rtl/vcxo_lock_monitor.sv
// VCXO lock monitor: qualifies frequency-error measurements, runs the lock FSM,
// flags PWM rail saturation and serves an atomic 8-byte status snapshot to the MCU.
module vcxo_lock_monitor #(
    parameter int LOCK_TOL       = 16,
    parameter int LOCK_COUNT     = 8,
    parameter int UNLOCK_COUNT   = 3,
    parameter int PWM_MAX        = 1000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               meas_strobe,
    input  logic signed [23:0] freq_error,
    input  logic signed [23:0] PWM,
    input  logic               rd_start,
    input  logic               rd_next,
    output logic [7:0]         rd_byte,
    output logic [2:0]         rd_index,
    output logic [1:0]         lock_state,
    output logic               locked,
    output logic               rail
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_e;

    localparam logic signed [23:0] TOL_POS   = 24'(LOCK_TOL);
    localparam logic signed [23:0] TOL_NEG   = -TOL_POS;
    localparam logic signed [23:0] PWM_TOP   = 24'(PWM_MAX);
    localparam logic [31:0]        IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         GOOD_END  = 8'(LOCK_COUNT);
    localparam logic [7:0]         MISS_END  = 8'(UNLOCK_COUNT);

    state_e      state_q, state_d;
    logic [7:0]  good_q, good_d, miss_q, miss_d;
    logic [31:0] idle_q, idle_d;
    logic        locked_q, rail_q, tseen_q;
    logic [23:0] err_q, pwm_q;
    logic [7:0]  meas_cnt_q;
    logic [63:0] snap_q;
    logic [2:0]  idx_q;

    logic        in_tol_s, rail_s, timeout_hit_s;
    logic [7:0]  good_inc_s, miss_inc_s;

    // Both bounds compared signed, so -2^23 is simply out of tolerance.
    assign in_tol_s      = (freq_error >= TOL_NEG) && (freq_error <= TOL_POS);
    assign rail_s        = (PWM <= 24'sd0) || (PWM >= PWM_TOP);
    assign timeout_hit_s = !meas_strobe && (idle_q == IDLE_LAST);
    assign good_inc_s    = good_q + 8'd1;
    assign miss_inc_s    = miss_q + 8'd1;
    assign idle_d        = meas_strobe ? 32'd0 :
                           ((idle_q == IDLE_LAST) ? idle_q : idle_q + 32'd1);

    // Lock FSM next state; a strobe always takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        if (meas_strobe) begin
            case (state_q)
                ST_UNLOCKED, ST_HOLDOVER: begin
                    if (in_tol_s) begin
                        state_d = ST_ACQUIRE;
                        good_d  = 8'd1;
                    end else begin
                        state_d = ST_UNLOCKED;
                        good_d  = 8'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (in_tol_s) begin
                        good_d = good_inc_s;
                        if (good_inc_s == GOOD_END) begin
                            state_d = ST_LOCKED;
                            miss_d  = 8'd0;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                        good_d  = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (in_tol_s) begin
                        miss_d = 8'd0;
                    end else if (miss_inc_s == MISS_END) begin
                        state_d = ST_UNLOCKED;
                        good_d  = 8'd0;
                        miss_d  = 8'd0;
                    end else begin
                        miss_d = miss_inc_s;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    good_d  = 8'd0;
                    miss_d  = 8'd0;
                end
            endcase
        end else if (timeout_hit_s) begin
            state_d = ST_HOLDOVER;
            good_d  = 8'd0;
            miss_d  = 8'd0;
        end else begin
            state_d = state_q;
        end
    end

    // FSM state, lock counters, idle timer and registered status flags.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_UNLOCKED;
            good_q   <= 8'd0;
            miss_q   <= 8'd0;
            idle_q   <= 32'd0;
            locked_q <= 1'b0;
            rail_q   <= 1'b0;
            tseen_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            idle_q   <= idle_d;
            locked_q <= (state_d == ST_LOCKED);
            rail_q   <= meas_strobe ? rail_s : rail_q;
            tseen_q  <= timeout_hit_s ? 1'b1 : (rd_start ? 1'b0 : tseen_q);
        end
    end

    // Measurement shadows, strobe counter and snapshot (captures pre-edge contents).
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            err_q      <= 24'd0;
            pwm_q      <= 24'd0;
            meas_cnt_q <= 8'd0;
            snap_q     <= 64'd0;
        end else begin
            if (meas_strobe) begin
                err_q <= freq_error;
                pwm_q <= PWM;
            end
            if (rd_start) begin
                meas_cnt_q <= meas_strobe ? 8'd1 : 8'd0;
                snap_q     <= {3'b000, tseen_q, rail_q, locked_q, state_q,
                               err_q, pwm_q, meas_cnt_q};
            end else if (meas_strobe && (meas_cnt_q != 8'hFF)) begin
                meas_cnt_q <= meas_cnt_q + 8'd1;
            end
        end
    end

    // Read pointer; rd_start has priority over rd_next.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= 3'd0;
        end else if (rd_start) begin
            idx_q <= 3'd0;
        end else if (rd_next) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    // Byte select from the snapshot register, byte0 in the top bits.
    always_comb begin
        rd_byte = 8'h00;
        case (idx_q)
            3'd0:    rd_byte = snap_q[63:56];
            3'd1:    rd_byte = snap_q[55:48];
            3'd2:    rd_byte = snap_q[47:40];
            3'd3:    rd_byte = snap_q[39:32];
            3'd4:    rd_byte = snap_q[31:24];
            3'd5:    rd_byte = snap_q[23:16];
            3'd6:    rd_byte = snap_q[15:8];
            3'd7:    rd_byte = snap_q[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    assign rd_index   = idx_q;
    assign lock_state = state_q;
    assign locked     = locked_q;
    assign rail       = rail_q;

endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// Directed bench for vcxo_lock_monitor with hand-computed expectations.
module tb_vcxo_lock_monitor;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        meas_strobe;
    logic [23:0] freq_error;
    logic [23:0] PWM;
    logic        rd_start;
    logic        rd_next;
    logic [7:0]  rd_byte;
    logic [2:0]  rd_index;
    logic [1:0]  lock_state;
    logic        locked;
    logic        rail;

    int n_vec = 0;
    int n_err = 0;

    vcxo_lock_monitor #(.TIMEOUT_CYCLES(100)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .meas_strobe (meas_strobe),
        .freq_error  (freq_error),
        .PWM         (PWM),
        .rd_start    (rd_start),
        .rd_next     (rd_next),
        .rd_byte     (rd_byte),
        .rd_index    (rd_index),
        .lock_state  (lock_state),
        .locked      (locked),
        .rail        (rail)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, driven at negedge; returns 1 time unit after the posedge.
    task automatic cyc(input logic stb, input logic rs, input logic rn,
                       input logic [23:0] err, input logic [23:0] pwm);
        @(negedge clk_in);
        meas_strobe = stb;
        rd_start    = rs;
        rd_next     = rn;
        freq_error  = err;
        PWM         = pwm;
        @(posedge clk_in);
        #1;
        meas_strobe = 1'b0;
        rd_start    = 1'b0;
        rd_next     = 1'b0;
    endtask

    logic [23:0] t2_err [6] = '{24'd40, 24'd40, 24'd3, 24'd40, 24'd40, 24'd40};
    logic [1:0]  t2_st  [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic [23:0] t3_err [5] = '{24'hFFFFF0, 24'h000010, 24'hFFFFEF, 24'h000000, 24'h800000};
    logic [1:0]  t3_st  [5] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0};
    logic [7:0]  t5_b   [8] = '{8'h08, 8'h12, 8'h34, 8'h56, 8'h00, 8'h03, 8'hE8, 8'h01};

    initial begin
        reset_n = 1'b0; meas_strobe = 1'b0; rd_start = 1'b0; rd_next = 1'b0;
        freq_error = 24'd0; PWM = 24'd500;
        repeat (2) @(posedge clk_in);
        #1;
        check_vec("rst_state", 32'(lock_state), 32'd0);
        check_vec("rst_locked", 32'(locked), 32'd0);
        check_vec("rst_rail", 32'(rail), 32'd0);
        check_vec("rst_index", 32'(rd_index), 32'd0);
        check_vec("rst_byte", 32'(rd_byte), 32'd0);
        @(negedge clk_in);
        reset_n = 1'b1;

        // 1: acquisition to lock with err=+5
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 24'd5, 24'd500);
            check_vec($sformatf("acq_state%0d", i), 32'(lock_state), (i < 8) ? 32'd1 : 32'd2);
            check_vec($sformatf("acq_locked%0d", i), 32'(locked), (i < 8) ? 32'd0 : 32'd1);
        end

        // 2: miss counter resets on an in-tolerance sample
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, t2_err[i], 24'd500);
            check_vec($sformatf("miss_state%0d", i), 32'(lock_state), 32'(t2_st[i]));
        end
        check_vec("miss_locked", 32'(locked), 32'd0);

        // 3: tolerance boundaries
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, t3_err[i], 24'd500);
            check_vec($sformatf("tol_state%0d", i), 32'(lock_state), 32'(t3_st[i]));
        end

        // 4: timeout to HOLDOVER after exactly 100 idle cycles
        repeat (99) @(posedge clk_in);
        #1;
        check_vec("to_before", 32'(lock_state), 32'd0);
        @(posedge clk_in);
        #1;
        check_vec("to_hold", 32'(lock_state), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 24'd0, 24'd500);
        check_vec("to_byte0", 32'(rd_byte), 32'h13);
        cyc(1'b1, 1'b0, 1'b0, 24'd0, 24'd500);
        check_vec("to_reacq", 32'(lock_state), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 24'd0, 24'd500);
        check_vec("to_clr_byte0", 32'(rd_byte), 32'h11);

        // 5: full snapshot readout with rail asserted
        cyc(1'b1, 1'b0, 1'b0, 24'h123456, 24'd1000);
        check_vec("rd_state", 32'(lock_state), 32'd0);
        check_vec("rd_rail", 32'(rail), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 24'd0, 24'd500);
        for (int i = 0; i < 8; i++) begin
            check_vec($sformatf("rd_idx%0d", i), 32'(rd_index), 32'(i));
            check_vec($sformatf("rd_byte%0d", i), 32'(rd_byte), 32'(t5_b[i]));
            cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        end
        check_vec("rd_wrap_idx", 32'(rd_index), 32'd0);
        check_vec("rd_wrap_byte", 32'(rd_byte), 32'h08);
        cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        check_vec("rd_idx2", 32'(rd_index), 32'd2);
        cyc(1'b0, 1'b1, 1'b1, 24'd0, 24'd500);
        check_vec("rd_both_idx", 32'(rd_index), 32'd0);

        // 6: strobe coinciding with rd_start is excluded from that snapshot
        cyc(1'b1, 1'b1, 1'b0, 24'd7, 24'd500);
        check_vec("co_state", 32'(lock_state), 32'd1);
        check_vec("co_byte0", 32'(rd_byte), 32'h08);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        check_vec("co_byte3", 32'(rd_byte), 32'h56);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        check_vec("co_byte7", 32'(rd_byte), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, 24'd0, 24'd500);
        check_vec("nx_byte0", 32'(rd_byte), 32'h01);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        check_vec("nx_byte3", 32'(rd_byte), 32'h07);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 24'd0, 24'd500);
        check_vec("nx_byte7", 32'(rd_byte), 32'h01);
        check_vec("nx_idx7", 32'(rd_index), 32'd7);

        // Asynchronous reset mid-readout
        @(negedge clk_in);
        reset_n = 1'b0;
        #1;
        check_vec("ar_idx", 32'(rd_index), 32'd0);
        check_vec("ar_byte0", 32'(rd_byte), 32'h00);
        check_vec("ar_state", 32'(lock_state), 32'd0);
        check_vec("ar_rail", 32'(rail), 32'd0);
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
